// File: rtl/mbox_pkg.sv
// Shared types and constants for the MBOX request sequencer.
package mbox_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RESP,
    PSE_HOLD
  } mboxState_t;

  typedef logic [0:35]  word_t;
  typedef logic [13:35] vma_t;

  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int TIMER_W            = 8;

endpackage

// File: rtl/mbox_nxm_timer.sv
// Nonexistent-memory watchdog: cleared on cycle start, counts while a
// memory request is outstanding, flags the cycle on which the limit is hit.
module mbox_nxm_timer
  import mbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rstN,
  input  logic load,
  input  logic en,
  output logic termCnt
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th cycle of an outstanding request.
  assign termCnt = en && !load && (count == LAST);

endmodule

// File: rtl/mbox_req_seq.sv
// Sequences one EBOX memory request at a time onto a req/ack memory port,
// with read parity checking and NXM timeout.
module mbox_req_seq
  import mbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic  clk,
  input  logic  CROBAR,
  input  logic  EBOX_REQ,
  input  vma_t  EBOX_VMA,
  input  logic  eboxRead,
  input  logic  eboxWrite,
  input  logic  eboxPSE,
  input  word_t cacheDataWrite,
  input  logic  errClr,
  output logic  mboxRespIn,
  output word_t cacheDataRead,
  output logic  mboxBusy,
  output logic  nxmErr,
  output logic  mbParErr,
  output logic  memReq,
  output logic  memWrite,
  output vma_t  memAdr,
  output word_t memWData,
  input  logic  memAck,
  input  word_t memRData,
  input  logic  memRPar
);

  mboxState_t state;
  logic       pauseFlag;
  logic       acceptOk;
  logic       startRead;
  logic       startWrite;
  logic       timerDone;

  assign acceptOk   = (state == IDLE) || (state == PSE_HOLD);
  assign startRead  = acceptOk && EBOX_REQ && eboxRead;
  assign startWrite = acceptOk && EBOX_REQ && eboxWrite && !eboxRead;

  mbox_nxm_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uNxmTimer (
    .clk    (clk),
    .rstN   (CROBAR),
    .load   (startRead || startWrite),
    .en     (memReq),
    .termCnt(timerDone)
  );

  always_ff @(posedge clk or negedge CROBAR) begin
    if (!CROBAR) begin
      state         <= IDLE;
      pauseFlag     <= 1'b0;
      mboxRespIn    <= 1'b0;
      cacheDataRead <= '0;
      mboxBusy      <= 1'b0;
      nxmErr        <= 1'b0;
      mbParErr      <= 1'b0;
      memReq        <= 1'b0;
      memWrite      <= 1'b0;
      memAdr        <= '0;
      memWData      <= '0;
    end else begin
      // Error sets later in this block override a same-cycle clear.
      if (errClr) begin
        nxmErr   <= 1'b0;
        mbParErr <= 1'b0;
      end

      case (state)
        IDLE, PSE_HOLD: begin
          if (startRead) begin
            memAdr    <= EBOX_VMA;
            memWData  <= cacheDataWrite;
            pauseFlag <= eboxPSE || eboxWrite;
            memReq    <= 1'b1;
            memWrite  <= 1'b0;
            mboxBusy  <= 1'b1;
            state     <= RD;
          end else if (startWrite) begin
            // The write half of read-pause-write reuses the held address.
            if (state == IDLE) begin
              memAdr <= EBOX_VMA;
            end
            memWData  <= cacheDataWrite;
            pauseFlag <= 1'b0;
            memReq    <= 1'b1;
            memWrite  <= 1'b1;
            mboxBusy  <= 1'b1;
            state     <= WR;
          end
        end

        RD, WR: begin
          if (memAck) begin
            memReq     <= 1'b0;
            memWrite   <= 1'b0;
            mboxRespIn <= 1'b1;
            state      <= RESP;
            if (state == RD) begin
              cacheDataRead <= memRData;
              if (!(^{memRData, memRPar})) begin
                mbParErr <= 1'b1;
              end
            end
          end else if (timerDone) begin
            memReq     <= 1'b0;
            memWrite   <= 1'b0;
            mboxRespIn <= 1'b1;
            nxmErr     <= 1'b1;
            state      <= RESP;
            if (state == RD) begin
              cacheDataRead <= '0;
            end
          end
        end

        RESP: begin
          mboxRespIn <= 1'b0;
          mboxBusy   <= 1'b0;
          if (pauseFlag) begin
            state <= PSE_HOLD;
          end else begin
            pauseFlag <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbox_req_seq.sv
// Directed bench for mbox_req_seq: read, write, read-pause-write, NXM,
// parity and asynchronous reset behaviour.
module tb_mbox_req_seq;
  import mbox_pkg::*;

  logic  clk = 1'b0;
  logic  CROBAR = 1'b1;
  logic  EBOX_REQ = 1'b0;
  vma_t  EBOX_VMA = '0;
  logic  eboxRead = 1'b0;
  logic  eboxWrite = 1'b0;
  logic  eboxPSE = 1'b0;
  word_t cacheDataWrite = '0;
  logic  errClr = 1'b0;
  logic  mboxRespIn;
  word_t cacheDataRead;
  logic  mboxBusy;
  logic  nxmErr;
  logic  mbParErr;
  logic  memReq;
  logic  memWrite;
  vma_t  memAdr;
  word_t memWData;
  logic  memAck = 1'b0;
  word_t memRData = '0;
  logic  memRPar = 1'b0;

  int checks = 0;
  int failures = 0;
  int reqCycles;

  mbox_req_seq #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .CROBAR(CROBAR), .EBOX_REQ(EBOX_REQ), .EBOX_VMA(EBOX_VMA),
    .eboxRead(eboxRead), .eboxWrite(eboxWrite), .eboxPSE(eboxPSE),
    .cacheDataWrite(cacheDataWrite), .errClr(errClr), .mboxRespIn(mboxRespIn),
    .cacheDataRead(cacheDataRead), .mboxBusy(mboxBusy), .nxmErr(nxmErr),
    .mbParErr(mbParErr), .memReq(memReq), .memWrite(memWrite), .memAdr(memAdr),
    .memWData(memWData), .memAck(memAck), .memRData(memRData), .memRPar(memRPar)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkWord(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic request(input logic rd, input logic wr, input logic pse,
                         input logic [22:0] vma, input logic [35:0] wdata);
    EBOX_REQ = 1'b1; eboxRead = rd; eboxWrite = wr; eboxPSE = pse;
    EBOX_VMA = vma; cacheDataWrite = wdata;
    tick();
    EBOX_REQ = 1'b0; eboxRead = 1'b0; eboxWrite = 1'b0; eboxPSE = 1'b0;
  endtask

  initial begin
    // Asynchronous reset, checked before the first clock edge.
    #3 CROBAR = 1'b0;
    #1;
    chkBit("rst_memReq", memReq, 1'b0);
    chkBit("rst_busy", mboxBusy, 1'b0);
    chkBit("rst_resp", mboxRespIn, 1'b0);
    chkBit("rst_memWrite", memWrite, 1'b0);
    chkBit("rst_nxm", nxmErr, 1'b0);
    chkBit("rst_par", mbParErr, 1'b0);
    chkWord("rst_rdata", cacheDataRead, 36'o0);
    chkWord("rst_adr", {13'd0, memAdr}, 36'o0);
    chkWord("rst_wdata", memWData, 36'o0);
    repeat (2) tick();
    CROBAR = 1'b1;
    tick();

    // Read hit, memory acks on the third request cycle.
    request(1'b1, 1'b0, 1'b0, 23'o1234, 36'o0);
    chkBit("rd_memReq", memReq, 1'b1);
    chkBit("rd_memWrite", memWrite, 1'b0);
    chkBit("rd_busy", mboxBusy, 1'b1);
    chkWord("rd_adr", {13'd0, memAdr}, 36'o1234);
    repeat (2) tick();
    memAck = 1'b1; memRData = 36'o123456701234; memRPar = 1'b0;
    chkBit("rd_resp_early", mboxRespIn, 1'b0);
    tick();
    memAck = 1'b0;
    chkBit("rd_memReq_drop", memReq, 1'b0);
    chkBit("rd_resp", mboxRespIn, 1'b1);
    chkWord("rd_data", cacheDataRead, 36'o123456701234);
    chkBit("rd_par", mbParErr, 1'b0);
    chkBit("rd_nxm", nxmErr, 1'b0);
    tick();
    chkBit("rd_resp_pulse", mboxRespIn, 1'b0);
    chkBit("rd_idle", mboxBusy, 1'b0);

    // Write with zero-wait memory.
    request(1'b0, 1'b1, 1'b0, 23'o555, 36'o777000111222);
    chkBit("wr_memWrite", memWrite, 1'b1);
    chkWord("wr_wdata", memWData, 36'o777000111222);
    chkWord("wr_adr", {13'd0, memAdr}, 36'o555);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chkBit("wr_resp", mboxRespIn, 1'b1);
    chkWord("wr_rdata_kept", cacheDataRead, 36'o123456701234);
    tick();
    chkBit("wr_resp_pulse", mboxRespIn, 1'b0);

    // Read-pause-write: the write goes to the held read address.
    request(1'b1, 1'b0, 1'b1, 23'o200, 36'o0);
    memAck = 1'b1; memRData = 36'o0; memRPar = 1'b1;
    tick();
    memAck = 1'b0;
    chkBit("rpw_resp", mboxRespIn, 1'b1);
    repeat (2) tick();
    chkBit("rpw_hold_busy", mboxBusy, 1'b0);
    chkBit("rpw_hold_req", memReq, 1'b0);
    request(1'b0, 1'b1, 1'b0, 23'o300, 36'o1);
    chkBit("rpw_wr_req", memWrite, 1'b1);
    chkWord("rpw_wr_adr", {13'd0, memAdr}, 36'o200);
    chkWord("rpw_wr_data", memWData, 36'o1);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
    request(1'b0, 1'b1, 1'b0, 23'o400, 36'o2);
    chkWord("rpw_after_adr", {13'd0, memAdr}, 36'o400);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();

    // NXM timeout on a read.
    request(1'b1, 1'b0, 1'b0, 23'o7777, 36'o0);
    reqCycles = 0;
    for (int i = 0; i < 100 && memReq; i++) begin
      reqCycles++;
      tick();
    end
    chkWord("nxm_req_cycles", 36'(reqCycles), 36'd64);
    chkBit("nxm_resp", mboxRespIn, 1'b1);
    chkBit("nxm_err", nxmErr, 1'b1);
    chkWord("nxm_rdata", cacheDataRead, 36'o0);
    tick();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    chkBit("nxm_clr", nxmErr, 1'b0);

    // Ack on the terminal-count cycle beats the timeout.
    request(1'b1, 1'b0, 1'b0, 23'o7770, 36'o0);
    repeat (63) tick();
    chkBit("tc_memReq", memReq, 1'b1);
    memAck = 1'b1; memRData = 36'o5; memRPar = 1'b1;
    tick();
    memAck = 1'b0;
    chkBit("tc_resp", mboxRespIn, 1'b1);
    chkBit("tc_nxm", nxmErr, 1'b0);
    chkWord("tc_rdata", cacheDataRead, 36'o5);
    tick();

    // Bad parity; a request during the busy cycle is ignored.
    request(1'b1, 1'b0, 1'b0, 23'o10, 36'o0);
    request(1'b1, 1'b0, 1'b0, 23'o20, 36'o0);
    chkWord("par_adr_kept", {13'd0, memAdr}, 36'o10);
    memAck = 1'b1; memRData = 36'o123456701234; memRPar = 1'b1;
    tick();
    memAck = 1'b0;
    chkBit("par_resp", mboxRespIn, 1'b1);
    chkBit("par_err", mbParErr, 1'b1);
    chkWord("par_data", cacheDataRead, 36'o123456701234);
    repeat (2) tick();
    chkBit("par_no_second_req", memReq, 1'b0);
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    chkBit("par_clr", mbParErr, 1'b0);

    // Same-cycle set and clear: the set wins.
    request(1'b1, 1'b0, 1'b0, 23'o11, 36'o0);
    memAck = 1'b1; memRPar = 1'b1; errClr = 1'b1;
    tick();
    memAck = 1'b0; errClr = 1'b0;
    chkBit("par_set_wins", mbParErr, 1'b1);
    tick();

    // Reset during a read, then a stale ack after release.
    request(1'b1, 1'b0, 1'b0, 23'o33, 36'o0);
    chkBit("mid_memReq", memReq, 1'b1);
    #2 CROBAR = 1'b0;
    #1;
    chkBit("mid_rst_memReq", memReq, 1'b0);
    chkBit("mid_rst_busy", mboxBusy, 1'b0);
    chkBit("mid_rst_par", mbParErr, 1'b0);
    chkWord("mid_rst_adr", {13'd0, memAdr}, 36'o0);
    chkWord("mid_rst_rdata", cacheDataRead, 36'o0);
    tick();
    CROBAR = 1'b1;
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chkBit("late_ack_resp", mboxRespIn, 1'b0);
    chkBit("late_ack_req", memReq, 1'b0);
    tick();
    chkBit("late_ack_resp2", mboxRespIn, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
